// File: rtl/mac_seq.sv
// Layer sequencer for the MAC accumulator: streams input/weight pairs, clears between
// neurons, saturates each sum into an 11-bit activation-LUT address. Option: MAC_SEQ_RELU_EN.
module mac_seq #(
  parameter  int N_IN   = 784,
  parameter  int N_OUT  = 32,
  localparam int IN_AW  = $clog2(N_IN),
  // a single-neuron layer still needs a 1-bit neuron index
  localparam int OUT_AW = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int WT_AW  = $clog2(N_IN * N_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic [IN_AW-1:0]         in_addr,
  input  logic signed [7:0]        in_data,
  output logic [WT_AW-1:0]         wt_addr,
  input  logic signed [7:0]        wt_data,
  output logic signed [7:0]        mac_a,
  output logic signed [7:0]        mac_b,
  output logic                     mac_clr_n,
  input  logic signed [25:0]       mac_acc,
  output logic [10:0]              act_addr,
  output logic [OUT_AW-1:0]        act_neuron,
  output logic                     act_valid,
  output logic                     done
);

  typedef enum logic [2:0] {IDLE, CLR, MAC, DRAIN, SAT} state_t;

  state_t             state, state_n;
  logic [OUT_AW-1:0]  neuron;
  logic [WT_AW-1:0]   wt_cnt;
  logic               op_vld;
  logic               last_in, last_neuron, issue;
  logic signed [25:0] sh;
  logic signed [10:0] sat;
  logic [10:0]        sat_addr;

  assign last_in     = (in_addr == IN_AW'(N_IN - 1));
  assign last_neuron = (neuron == OUT_AW'(N_OUT - 1));
  // an address is presented on every edge that lands in MAC
  assign issue       = (state == CLR) || (state == MAC && !last_in);

  // RAM data arrives one cycle after its address; zeros in between leave acc unchanged
  assign mac_a     = op_vld ? in_data : '0;
  assign mac_b     = op_vld ? wt_data : '0;
  assign mac_clr_n = !(rst || state == CLR);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CLR;
      CLR:     state_n = MAC;
      MAC:     if (last_in) state_n = DRAIN;
      DRAIN:   state_n = SAT;
      SAT:     state_n = last_neuron ? IDLE : CLR;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sh = mac_acc >>> 7;
    if (sh > 26'sd1023)       sat = 11'sd1023;
    else if (sh < -26'sd1024) sat = 11'h400;
    else                      sat = sh[10:0];
`ifdef MAC_SEQ_RELU_EN
    if (sh < 0) sat = '0;
`endif
    sat_addr = $unsigned(sat) + 11'd1024;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neuron     <= '0;
      wt_cnt     <= '0;
      op_vld     <= 1'b0;
      in_addr    <= '0;
      wt_addr    <= '0;
      act_addr   <= '0;
      act_neuron <= '0;
      act_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      op_vld    <= (state == MAC);
      act_valid <= 1'b0;
      done      <= 1'b0;
      if (state == IDLE && start) begin
        neuron <= '0;
        wt_cnt <= '0;
      end
      // weight address is a running count across neurons, not neuron*N_IN+i
      if (issue) begin
        in_addr <= (state == CLR) ? '0 : in_addr + 1'b1;
        wt_addr <= wt_cnt;
        wt_cnt  <= wt_cnt + 1'b1;
      end
      if (state == SAT) begin
        act_addr   <= sat_addr;
        act_neuron <= neuron;
        act_valid  <= 1'b1;
        if (last_neuron) done   <= 1'b1;
        else             neuron <= neuron + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq: small (4x2) and large (784x2) layers, each with RAM and MAC models.
module tb_mac_seq;
  localparam int SN = 4, SO = 2, BN = 784, BO = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  int n_vec = 0, n_err = 0;

  typedef struct {int neuron; int addr; int cyc;} exp_t;
  exp_t s_q[$], b_q[$];

  // small instance
  logic               s_start = 1'b0;
  logic [1:0]         s_in_addr;
  logic [2:0]         s_wt_addr;
  logic signed [7:0]  s_in_data, s_wt_data, s_mac_a, s_mac_b;
  logic               s_clr_n, s_act_valid, s_done;
  logic signed [25:0] s_acc;
  logic [10:0]        s_act_addr;
  logic [0:0]         s_act_neuron;
  logic signed [7:0]  s_in_mem[SN];
  logic signed [7:0]  s_wt_mem[SN*SO];

  // large instance
  logic               b_start = 1'b0;
  logic [9:0]         b_in_addr;
  logic [10:0]        b_wt_addr;
  logic signed [7:0]  b_in_data, b_wt_data, b_mac_a, b_mac_b;
  logic               b_clr_n, b_act_valid, b_done;
  logic signed [25:0] b_acc;
  logic [10:0]        b_act_addr;
  logic [0:0]         b_act_neuron;
  logic signed [7:0]  b_in_mem[BN];
  logic signed [7:0]  b_wt_mem[BN*BO];

  mac_seq #(.N_IN(SN), .N_OUT(SO)) u_small (
    .clk(clk), .rst(rst), .start(s_start),
    .in_addr(s_in_addr), .in_data(s_in_data), .wt_addr(s_wt_addr), .wt_data(s_wt_data),
    .mac_a(s_mac_a), .mac_b(s_mac_b), .mac_clr_n(s_clr_n), .mac_acc(s_acc),
    .act_addr(s_act_addr), .act_neuron(s_act_neuron), .act_valid(s_act_valid), .done(s_done));

  mac_seq #(.N_IN(BN), .N_OUT(BO)) u_big (
    .clk(clk), .rst(rst), .start(b_start),
    .in_addr(b_in_addr), .in_data(b_in_data), .wt_addr(b_wt_addr), .wt_data(b_wt_data),
    .mac_a(b_mac_a), .mac_b(b_mac_b), .mac_clr_n(b_clr_n), .mac_acc(b_acc),
    .act_addr(b_act_addr), .act_neuron(b_act_neuron), .act_valid(b_act_valid), .done(b_done));

  // sync-read RAMs and the external accumulator
  always @(posedge clk) begin
    s_in_data <= s_in_mem[s_in_addr];
    s_wt_data <= s_wt_mem[s_wt_addr];
    s_acc     <= !s_clr_n ? 26'sd0 : s_acc + 26'(int'(s_mac_a) * int'(s_mac_b));
    b_in_data <= b_in_mem[b_in_addr];
    b_wt_data <= b_wt_mem[b_wt_addr];
    b_acc     <= !b_clr_n ? 26'sd0 : b_acc + 26'(int'(b_mac_a) * int'(b_mac_b));
  end

  function automatic int ref_addr(input longint acc);
    longint s;
    s = acc >>> 7;
`ifdef MAC_SEQ_RELU_EN
    if (s < 0) s = 0;
`endif
    if (s > 1023)  s = 1023;
    if (s < -1024) s = -1024;
    return int'(s) + 1024;
  endfunction

  task automatic push_small();
    for (int n = 0; n < SO; n++) begin
      longint acc = 0;
      for (int i = 0; i < SN; i++) acc += longint'(s_in_mem[i]) * longint'(s_wt_mem[n*SN+i]);
      s_q.push_back('{n, ref_addr(acc), (n+1)*(SN+3)});
    end
  endtask

  task automatic push_big();
    for (int n = 0; n < BO; n++) begin
      longint acc = 0;
      for (int i = 0; i < BN; i++) acc += longint'(b_in_mem[i]) * longint'(b_wt_mem[n*BN+i]);
      b_q.push_back('{n, ref_addr(acc), (n+1)*(BN+3)});
    end
  endtask

  // Starts a small layer at the current negedge; optionally pulses start again at pulse_cyc.
  task automatic run_small(input int pulse_cyc);
    int cyc, done_cyc, ph, nn;
    exp_t e;
    push_small();
    s_start = 1'b1;
    cyc = -1;
    done_cyc = -1;
    while (done_cyc < 0 && cyc < SO*(SN+3) + 10) begin
      @(negedge clk);
      cyc++;
      s_start = (cyc == pulse_cyc);
      ph = cyc % (SN+3);
      nn = cyc / (SN+3);
      if (cyc < SO*(SN+3)) begin
        n_vec++;
        if (s_clr_n !== (ph != 0))
          begin n_err++; $display("FAIL clr_n cyc %0d: got %b want %b", cyc, s_clr_n, ph != 0); end
        if (ph == 0 || ph == SN+2) begin
          n_vec++;
          if (s_mac_a !== 8'sd0 || s_mac_b !== 8'sd0)
            begin n_err++; $display("FAIL idle_operands cyc %0d: got a=%0d b=%0d want 0", cyc, s_mac_a, s_mac_b); end
        end
        if (ph >= 1 && ph <= SN) begin
          n_vec++;
          if (s_in_addr !== 2'(ph-1) || s_wt_addr !== 3'(nn*SN+ph-1))
            begin n_err++; $display("FAIL addr cyc %0d: got in=%0d wt=%0d want in=%0d wt=%0d", cyc, s_in_addr, s_wt_addr, ph-1, nn*SN+ph-1); end
        end
      end
      if (s_act_valid) begin
        n_vec++;
        if (s_q.size() == 0) begin n_err++; $display("FAIL small_extra_valid cyc %0d: got act_valid=1 want 0", cyc); end
        else begin
          e = s_q.pop_front();
          if (s_act_addr !== 11'(e.addr) || s_act_neuron !== 1'(e.neuron) || cyc != e.cyc) begin
            n_err++;
            $display("FAIL small_act: got addr=%0d neuron=%0d cyc=%0d want addr=%0d neuron=%0d cyc=%0d",
                     s_act_addr, s_act_neuron, cyc, e.addr, e.neuron, e.cyc);
          end
        end
      end
      if (s_done) done_cyc = cyc;
    end
    n_vec++;
    if (done_cyc != SO*(SN+3)) begin n_err++; $display("FAIL small_done: got cyc %0d want %0d", done_cyc, SO*(SN+3)); end
    n_vec++;
    if (s_q.size() != 0) begin n_err++; $display("FAIL small_missing: got %0d results left want 0", s_q.size()); end
    s_q.delete();
  endtask

  task automatic run_big();
    int cyc, done_cyc;
    exp_t e;
    push_big();
    b_start = 1'b1;
    cyc = -1;
    done_cyc = -1;
    while (done_cyc < 0 && cyc < BO*(BN+3) + 10) begin
      @(negedge clk);
      cyc++;
      b_start = 1'b0;
      if (b_act_valid) begin
        n_vec++;
        if (b_q.size() == 0) begin n_err++; $display("FAIL big_extra_valid cyc %0d: got act_valid=1 want 0", cyc); end
        else begin
          e = b_q.pop_front();
          if (b_act_addr !== 11'(e.addr) || b_act_neuron !== 1'(e.neuron) || cyc != e.cyc) begin
            n_err++;
            $display("FAIL big_act: got addr=%0d neuron=%0d cyc=%0d want addr=%0d neuron=%0d cyc=%0d",
                     b_act_addr, b_act_neuron, cyc, e.addr, e.neuron, e.cyc);
          end
        end
      end
      if (b_done) done_cyc = cyc;
    end
    n_vec++;
    if (done_cyc != BO*(BN+3)) begin n_err++; $display("FAIL big_done: got cyc %0d want %0d", done_cyc, BO*(BN+3)); end
    n_vec++;
    if (b_q.size() != 0) begin n_err++; $display("FAIL big_missing: got %0d results left want 0", b_q.size()); end
    b_q.delete();
  endtask

  task automatic fill_small(input int in_v, input int wt_v);
    for (int i = 0; i < SN; i++) s_in_mem[i] = 8'(in_v);
    for (int i = 0; i < SN*SO; i++) s_wt_mem[i] = 8'(wt_v);
  endtask

  task automatic fill_small_rand();
    for (int i = 0; i < SN; i++) s_in_mem[i] = 8'($urandom);
    for (int i = 0; i < SN*SO; i++) s_wt_mem[i] = 8'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    n_vec++;
    if (s_clr_n !== 1'b0 || s_act_valid !== 1'b0 || s_done !== 1'b0 || s_in_addr !== 2'd0 ||
        s_wt_addr !== 3'd0 || s_act_addr !== 11'd0 || s_act_neuron !== 1'd0 || s_mac_a !== 8'sd0) begin
      n_err++;
      $display("FAIL %s: got clr_n=%b av=%b done=%b in=%0d wt=%0d act=%0d nrn=%0d a=%0d want all 0",
               tag, s_clr_n, s_act_valid, s_done, s_in_addr, s_wt_addr, s_act_addr, s_act_neuron, s_mac_a);
    end
  endtask

  task automatic test_reset();
    bit stray;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_init");
    rst = 1'b0;
    fill_small(127, 127);
    @(negedge clk); s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_mid");
    rst = 1'b0;
    stray = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (s_act_valid || s_done) stray = 1'b1;
    end
    n_vec++;
    if (stray) begin n_err++; $display("FAIL reset_discard: got act_valid/done after reset want none"); end
    run_small(-1);
  endtask

  task automatic test_basic();
    @(negedge clk);
    fill_small(127, 127);
    run_small(-1);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    fill_small_rand();
    run_small(-1);
    fill_small_rand();
    run_small(-1);
  endtask

  task automatic test_handshake();
    @(negedge clk);
    fill_small_rand();
    run_small(3);
    @(negedge clk);
    fill_small_rand();
    run_small(SN + 3 + 2);
  endtask

  task automatic test_rounding();
    @(negedge clk);
    fill_small(0, 0);
    s_in_mem[0] = -8'sd1;
    s_wt_mem[0] = 8'sd1;
    run_small(-1);
  endtask

  task automatic test_saturation();
    @(negedge clk);
    for (int i = 0; i < BN; i++) begin
      b_in_mem[i]    = 8'sd127;
      b_wt_mem[i]    = 8'sd127;
      b_wt_mem[BN+i] = -8'sd128;
    end
    run_big();
  endtask

  initial begin
    fill_small(0, 0);
    for (int i = 0; i < BN; i++) b_in_mem[i] = '0;
    for (int i = 0; i < BN*BO; i++) b_wt_mem[i] = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_handshake();
    test_rounding();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
